// File: rtl/imu_cfg_seq.sv
// imu_cfg_seq -- MPU-9250 power-up configuration sequencer.
//
// Plays a fixed table of eight register writes into the IMU through the
// byte-level SPI master, owning chip-select for each two-byte transaction
// and inserting settling delays after the device reset and wake writes.
//
// Optional readback verification: define IMU_CFG_VERIFY_EN. Each entry from
// 2 onward is then read back and compared. A mismatch rewrites the entry,
// and the third consecutive mismatch on one entry ends in ERROR.
//
// Parameters:
//   WAIT_BITS  settling delay after entries 0 and 1 is 2^WAIT_BITS cycles
//   HOLD_BITS  CS-high gap after each transaction is 2^HOLD_BITS cycles
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   go           one-cycle run request (honoured in IDLE/DONE/ERROR)
//   spi_busy     SPI master busy
//   spi_finish   one-cycle byte-complete pulse
//   spi_data     received byte, valid with spi_finish
//   spi_start    registered one-cycle byte start
//   spi_addr     byte to shift out, held until spi_finish
//   imu_cs_n     sensor chip-select, active-low
//   busy         sequence in progress
//   done         table completed (level)
//   error        readback verification failed (level)
//   step         current table entry
module imu_cfg_seq #(
    parameter int WAIT_BITS = 22,
    parameter int HOLD_BITS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       spi_busy,
    input  logic       spi_finish,
    input  logic [7:0] spi_data,
    output logic       spi_start,
    output logic [7:0] spi_addr,
    output logic       imu_cs_n,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] step
);

    localparam int CNT_W = (WAIT_BITS > HOLD_BITS) ? WAIT_BITS : HOLD_BITS;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'({HOLD_BITS{1'b1}});
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'({WAIT_BITS{1'b1}});

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_DATA, S_GAP, S_WAIT, S_VADDR, S_VDATA,
        S_VGAP, S_CHECK, S_NEXT, S_DONE, S_ERROR
    } state_t;

    // {register, value} for each entry
    function automatic logic [15:0] tbl(input logic [2:0] i);
        case (i)
            3'd0:    tbl = 16'h6B80;
            3'd1:    tbl = 16'h6B00;
            3'd2:    tbl = 16'h6A10;
            3'd3:    tbl = 16'h1900;
            3'd4:    tbl = 16'h1A01;
            3'd5:    tbl = 16'h1B18;
            3'd6:    tbl = 16'h1C08;
            default: tbl = 16'h1D03;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sent_q, sent_d;   // start already issued for this byte
    logic             start_q, start_d;
    logic [7:0]       addr_q, addr_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, done_q;
    logic [15:0]      entry;
    logic [7:0]       reg_a, val;

`ifdef IMU_CFG_VERIFY_EN
    logic [1:0] retry_q, retry_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q;
`else
    logic unused_spi_data;
    assign unused_spi_data = ^spi_data;
`endif

    assign entry = tbl(step_q);
    assign reg_a = entry[15:8];
    assign val   = entry[7:0];

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = '0;          // every counting state clears it on entry
        sent_d  = sent_q;
        start_d = 1'b0;
        addr_d  = addr_q;
        cs_n_d  = cs_n_q;
`ifdef IMU_CFG_VERIFY_EN
        retry_d = retry_q;
        rdata_d = rdata_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    step_d  = 3'd0;
                    sent_d  = 1'b0;
                    state_d = S_ADDR;
`ifdef IMU_CFG_VERIFY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            S_ADDR: begin
                if (!sent_q && !spi_busy) begin
                    start_d = 1'b1;
                    sent_d  = 1'b1;
                    addr_d  = {1'b0, reg_a[6:0]};
                    cs_n_d  = 1'b0;
                end else if (sent_q && spi_finish) begin
                    sent_d  = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!sent_q && !spi_busy) begin
                    start_d = 1'b1;
                    sent_d  = 1'b1;
                    addr_d  = val;
                end else if (sent_q && spi_finish) begin
                    sent_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == HOLD_MAX) begin
                    if (step_q[2:1] == 2'b00) state_d = S_WAIT;
`ifdef IMU_CFG_VERIFY_EN
                    else                      state_d = S_VADDR;
`else
                    else                      state_d = S_NEXT;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // entries 0/1 are never read back: the reset bit self-clears
                if (cnt_q == WAIT_MAX) state_d = S_NEXT;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
`ifdef IMU_CFG_VERIFY_EN
            S_VADDR: begin
                if (!sent_q && !spi_busy) begin
                    start_d = 1'b1;
                    sent_d  = 1'b1;
                    addr_d  = {1'b1, reg_a[6:0]};
                    cs_n_d  = 1'b0;
                end else if (sent_q && spi_finish) begin
                    sent_d  = 1'b0;
                    state_d = S_VDATA;
                end
            end
            S_VDATA: begin
                if (!sent_q && !spi_busy) begin
                    start_d = 1'b1;
                    sent_d  = 1'b1;
                    addr_d  = 8'hFF;
                end else if (sent_q && spi_finish) begin
                    sent_d  = 1'b0;
                    rdata_d = spi_data;
                    cs_n_d  = 1'b1;
                    state_d = S_VGAP;
                end
            end
            S_VGAP: begin
                if (cnt_q == HOLD_MAX) state_d = S_CHECK;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_CHECK: begin
                if (rdata_q == val) begin
                    state_d = S_NEXT;
                end else if (retry_q == 2'd2) begin
                    state_d = S_ERROR;
                end else begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_ADDR;
                end
            end
`endif
            S_NEXT: begin
                if (step_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_ADDR;
`ifdef IMU_CFG_VERIFY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            cnt_q   <= '0;
            sent_q  <= 1'b0;
            start_q <= 1'b0;
            addr_q  <= 8'hFF;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
            done_q  <= (state_d == S_DONE);
        end
    end

`ifdef IMU_CFG_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= 2'd0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            retry_q <= retry_d;
            rdata_q <= rdata_d;
            err_q   <= (state_d == S_ERROR);
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign spi_start = start_q;
    assign spi_addr  = addr_q;
    assign imu_cs_n  = cs_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step      = step_q;

endmodule

// File: tb/tb_imu_cfg_seq.sv
// Bench for imu_cfg_seq with short delays (WAIT_BITS=4, HOLD_BITS=2).
// A behavioural SPI slave runs in the tick task on the falling edge; every
// byte the DUT starts is popped from the expected-byte queue and compared.
module tb_imu_cfg_seq;

    logic       clk = 1'b0;
    logic       rst, go, spi_busy, spi_finish;
    logic [7:0] spi_data;
    logic       spi_start, imu_cs_n, busy, done, error;
    logic [7:0] spi_addr;
    logic [2:0] step;

    always #5 clk = ~clk;

    imu_cfg_seq #(.WAIT_BITS(4), .HOLD_BITS(2)) dut (
        .clk(clk), .rst(rst), .go(go), .spi_busy(spi_busy),
        .spi_finish(spi_finish), .spi_data(spi_data), .spi_start(spi_start),
        .spi_addr(spi_addr), .imu_cs_n(imu_cs_n), .busy(busy), .done(done),
        .error(error), .step(step)
    );

    int nchk = 0;
    int nfail = 0;

    logic [7:0] t_reg [8] = '{8'h6B, 8'h6B, 8'h6A, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
    logic [7:0] t_val [8] = '{8'h80, 8'h00, 8'h10, 8'h00, 8'h01, 8'h18, 8'h08, 8'h03};

    logic [7:0] exp_q[$];
    logic [7:0] regs [128];
    logic [7:0] cur_addr, resp;
    int         sl_cnt, win_bytes, hi_run, txn_idx, bad1b;
    bit         prev_cs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, then run the CS monitor and slave.
    task automatic tick();
        @(negedge clk);
        spi_finish = 1'b0;
        if (rst) begin
            spi_busy  = 1'b0;
            sl_cnt    = 0;
            win_bytes = 0;
            hi_run    = 0;
            prev_cs   = 1'b1;
            return;
        end
        if (imu_cs_n) begin
            if (!prev_cs) begin
                chk("cs_window_bytes", win_bytes, 2);
                txn_idx++;
                hi_run = 0;
            end
            hi_run++;
        end else if (prev_cs) begin
            // after entries 0/1 the gap also contains the 16-cycle wait
            if (txn_idx > 0)
                chk("cs_high_gap", (hi_run >= ((txn_idx <= 2) ? 20 : 4)), 1);
            win_bytes = 0;
        end
        prev_cs = imu_cs_n;

        if (spi_start) begin
            chk("start_while_busy", spi_busy, 0);
            chk("cs_low_at_start", imu_cs_n, 0);
            win_bytes++;
            chk("byte_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("byte_value", spi_addr, exp_q.pop_front());
            if (win_bytes == 1) begin
                cur_addr = spi_addr;
                resp     = 8'hFF;
            end else begin
                if (!cur_addr[7]) regs[cur_addr[6:0]] = spi_addr;
                resp = regs[cur_addr[6:0]];
                if (cur_addr[7] && cur_addr[6:0] == 7'h1B && bad1b > 0) begin
                    resp = 8'h00;
                    bad1b--;
                end
            end
            spi_busy = 1'b1;
            sl_cnt   = 3;
        end else if (spi_busy) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                spi_busy   = 1'b0;
                spi_finish = 1'b1;
                spi_data   = resp;
            end
        end
    endtask

    // Expected byte stream: entries 0..last, entry 5 written e5_tries times.
    task automatic push_table(input int e5_tries, input int last);
        for (int e = 0; e <= last; e++) begin
            for (int k = 0; k < ((e == 5) ? e5_tries : 1); k++) begin
                exp_q.push_back(t_reg[e]);
                exp_q.push_back(t_val[e]);
`ifdef IMU_CFG_VERIFY_EN
                if (e >= 2) begin
                    exp_q.push_back(t_reg[e] | 8'h80);
                    exp_q.push_back(8'hFF);
                end
`endif
            end
        end
    endtask

    task automatic pulse_go();
        go      = 1'b1;
        txn_idx = 0;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_end(input int budget, input bit spam);
        for (int i = 0; i < budget; i++) begin
            go = spam && (i % 23 == 7);
            tick();
            if (done || error) break;
        end
        go = 1'b0;
        chk("run_ended_in_budget", (done || error), 1);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; spi_busy = 1'b0; spi_finish = 1'b0; spi_data = 8'h00;
        bad1b = 0; sl_cnt = 0; win_bytes = 0; hi_run = 0; txn_idx = 0; prev_cs = 1'b1;
        cur_addr = 8'h00; resp = 8'hFF;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        tick(); tick();
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_addr", spi_addr, 8'hFF);
        chk("rst_cs_n", imu_cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_step", step, 0);
        rst = 1'b0;
        tick();

        // run 1: latency go -> first start, then the full table
        push_table(1, 7);
        pulse_go();
        chk("go_busy_next_cycle", busy, 1);
        chk("go_no_start_yet", spi_start, 0);
        tick();
        chk("first_start", spi_start, 1);
        chk("first_cs_low", imu_cs_n, 0);
        chk("first_byte_addr", spi_addr, 8'h6B);
        wait_end(3000, 1'b0);
        chk("run1_done", done, 1);
        chk("run1_busy", busy, 0);
        chk("run1_error", error, 0);
        chk("run1_step", step, 7);
        chk("run1_queue_empty", exp_q.size(), 0);

        // run 2: restart from DONE, with go spammed while busy
        push_table(1, 7);
        pulse_go();
        chk("run2_busy", busy, 1);
        wait_end(3000, 1'b1);
        chk("run2_done", done, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("run2_no_extra_bytes", exp_q.size(), 0);
        chk("run2_stays_done", done, 1);

        // run 3: reset mid-byte on entry 3, then replay
        push_table(1, 7);
        pulse_go();
        for (int i = 0; i < 3000; i++) begin
            if (step == 3'd3 && spi_busy && !imu_cs_n) break;
            tick();
        end
        chk("reached_step3_midbyte", (step == 3'd3 && spi_busy), 1);
        rst = 1'b1;
        tick();
        chk("midrst_cs_n", imu_cs_n, 1);
        chk("midrst_start", spi_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_step", step, 0);
        chk("midrst_done", done, 0);
        exp_q.delete();
        go = 1'b1;            // coincident with reset: must be ignored
        tick();
        rst = 1'b0;
        go  = 1'b0;
        tick(); tick();
        chk("go_with_rst_ignored", busy, 0);
        chk("go_with_rst_cs", imu_cs_n, 1);
        push_table(1, 7);
        pulse_go();
        wait_end(3000, 1'b0);
        chk("run3_done", done, 1);
        chk("run3_queue_empty", exp_q.size(), 0);

`ifdef IMU_CFG_VERIFY_EN
        // one bad readback of 0x1B -> one rewrite
        bad1b = 1;
        push_table(2, 7);
        pulse_go();
        wait_end(4000, 1'b0);
        chk("retry_done", done, 1);
        chk("retry_error", error, 0);
        chk("retry_queue_empty", exp_q.size(), 0);

        // persistent bad readback -> three attempts then ERROR
        bad1b = 1000;
        push_table(3, 5);
        pulse_go();
        wait_end(4000, 1'b0);
        chk("err_error", error, 1);
        chk("err_done", done, 0);
        chk("err_busy", busy, 0);
        chk("err_step", step, 5);
        chk("err_queue_empty", exp_q.size(), 0);
        bad1b = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/imu_cfg_seq.md
# imu_cfg_seq

Configuration sequencer for the MPU-9250 IMU. It plays a fixed table of eight register writes into the sensor through the byte-level SPI master: device reset, wake, SPI-only mode, sample rate, DLPF, gyro FSR, accel FSR and accel DLPF. It inserts the required settling delays and owns chip-select across each two-byte transaction. It runs once after power-up, before the sampling state machine takes the bus, and signals completion or failure to that state machine.

## Interface
Parameters:
- WAIT_BITS, 22: post-reset and post-wake settling counter width; the delay is 2^WAIT_BITS cycles.
- HOLD_BITS, 12: inter-transaction gap counter width; the gap is 2^HOLD_BITS cycles with CS deasserted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- go  in  1  one-cycle request to run the table. Honoured only in IDLE, DONE or ERROR.
- spi_busy  in  1  SPI master busy.
- spi_finish  in  1  one-cycle pulse marking that a byte has completed.
- spi_data  in  8  received byte; valid in the spi_finish cycle.
- spi_start  out  1  registered one-cycle pulse that starts a byte.
- spi_addr  out  8  byte to shift out; held stable until spi_finish.
- imu_cs_n  out  1  sensor chip-select, active-low; held low across the address byte and the data byte.
- busy  out  1  sequence in progress.
- done  out  1  level; the table completed without error.
- error  out  1  level; verification failed (only with the macro enabled).
- step  out  3  index of the current table entry.

## Operation
Table, as entry: register <- value.
- 0: 0x6B <- 0x80
- 1: 0x6B <- 0x00
- 2: 0x6A <- 0x10
- 3: 0x19 <- 0x00
- 4: 0x1A <- 0x01
- 5: 0x1B <- 0x18
- 6: 0x1C <- 0x08
- 7: 0x1D <- 0x03

States:
- IDLE: wait for go. On go, step=0, clear done and error, go to ADDR.
- ADDR: drive imu_cs_n=0 and spi_addr={1'b0, reg[6:0]}. Pulse spi_start once when !spi_busy. On spi_finish go to DATA.
- DATA: spi_addr=value, one spi_start pulse. On spi_finish, set imu_cs_n=1 and go to GAP.
- GAP: count 2^HOLD_BITS cycles.
  - If step is 0 or 1, go to WAIT.
  - Otherwise go to VADDR if verify is compiled in, else NEXT.
- WAIT: count 2^WAIT_BITS cycles, then go to NEXT. Entry 0 skips verification, because the reset bit self-clears.
- NEXT: if step==7 go to DONE; else step+1, clear the retry count, go to ADDR.
- DONE: done=1, busy=0. A go restarts the table from entry 0.
- ERROR: error=1, busy=0. A go restarts the table from entry 0.

Handshake rules:
- At most one spi_start per byte.
- spi_start is never asserted while spi_busy=1.
- spi_finish arriving in any state other than ADDR, DATA, VADDR or VDATA is ignored.

Counters:
- Each counter clears on entry to its state.
- Terminal count is all-ones; the state exits on the following edge.

## Timing
- Reset values: spi_start=0, spi_addr=0xFF, imu_cs_n=1, busy=0, done=0, error=0, step=0, state=IDLE, all counters 0.
- Reset mid-sequence: every output returns to its reset value on the next edge. imu_cs_n rises immediately, even mid-byte. No resume.
- go to first spi_start: 2 cycles (IDLE→ADDR, then the registered start).
- imu_cs_n falls in the same cycle as the first spi_start of a transaction.
- imu_cs_n rises on the edge after the second spi_finish.
- busy is 1 from the cycle after go until DONE or ERROR is entered.
- step updates in the NEXT→ADDR cycle.
- go while busy is ignored. go coincident with rst is ignored.

## Configuration
- IMU_CFG_VERIFY_EN defined:
  - After GAP, VADDR sends {1'b1, reg[6:0]} and VDATA sends 0xFF. Both bytes go under one CS-low window, followed by a GAP.
  - CHECK compares the spi_data captured at the VDATA spi_finish against the table value.
  - Match: go to NEXT.
  - Mismatch: retry count +1, re-enter ADDR with the same step.
  - Third consecutive mismatch on an entry: go to ERROR.
- Undefined: no readback. error is tied to 0. Entry period = two bytes + GAP (+ WAIT for entries 0 and 1).

## Test plan
- Run with WAIT_BITS=4, HOLD_BITS=2 and a behavioural SPI-slave model. Pulse go → expect the byte stream 6B 80, 6B 00, 6A 10, 19 00, 1A 01, 1B 18, 1C 08, 1D 03. Then done=1, busy=0, error=0.
- Measure CS: imu_cs_n is low for exactly two bytes per transaction. Expect ≥4 CS-high cycles between transactions and ≥16 extra cycles after entries 0 and 1.
- Assert rst while step=3, mid-byte → the next cycle shows imu_cs_n=1, spi_start=0, busy=0, step=0. A new go replays from 6B 80.
- Pulse go repeatedly while busy → no restart, no extra bytes. After DONE, pulse go → the full table is replayed.
- With verify enabled, the slave returns 0x00 for register 0x1B once → one retry of 1B 18, then done=1.
- With verify enabled, the slave always returns 0x00 for 0x1B → three attempts, then error=1, done=0, step=5.
